// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// FSM states and the default operand width.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MDOP_MULT  = 3'd0;
    localparam logic [2:0] MDOP_MULTU = 3'd1;
    localparam logic [2:0] MDOP_DIV   = 3'd2;
    localparam logic [2:0] MDOP_DIVU  = 3'd3;
    localparam logic [2:0] MDOP_MTHI  = 3'd4;
    localparam logic [2:0] MDOP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling for the multiply/divide datapath: operand
// magnitudes going in, and sign-corrected HI/LO coming out.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               is_signed,
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    neg_a;
    logic                    neg_b;
    logic [2*WIDTH-1:0]      prod;

    assign sa    = op_a;
    assign sb    = op_b;
    assign neg_a = is_signed && (sa < 0);
    assign neg_b = is_signed && (sb < 0);
    assign mag_a = cond_neg(op_a, neg_a);
    assign mag_b = cond_neg(op_b, neg_b);
    assign prod  = cond_neg2(raw, neg_a ^ neg_b);

    // raw is {upper, lower}: product halves for MUL, {remainder, quotient} for DIV
    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (op_b == '0) begin
                res_lo = '1;
                res_hi = op_a;
            end else begin
                res_lo = cond_neg(raw[WIDTH-1:0], neg_a ^ neg_b);
                res_hi = cond_neg(raw[2*WIDTH-1:WIDTH], neg_a);
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU: one bit per cycle,
// result lands in HI/LO and stall freezes dependents while it runs.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int IDX_W = $clog2(WIDTH);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               is_signed;
    logic               is_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_a      (op_a),
        .op_b      (op_b),
        .is_signed (is_signed),
        .is_div    (is_div),
        .raw       (acc),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    logic [IDX_W-1:0]   bit_idx;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic               cnt_last;

    // Multiplier bits are taken LSB first, dividend bits MSB first, straight
    // from the latched magnitudes so the accumulator can start at zero.
    assign bit_idx   = cnt[IDX_W-1:0];
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[bit_idx] ? {1'b0, mag_a} : '0);
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
    assign div_trial = {acc[2*WIDTH-1:WIDTH], mag_a[~bit_idx]};
    assign div_diff  = {1'b0, div_trial} - {2'b00, mag_b};
    assign div_ge    = ~div_diff[WIDTH+1];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
    assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));

    assign stall = busy || (state == IDLE && start && mdop <= MDOP_DIVU);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        case (mdop)
                            MDOP_MULT, MDOP_MULTU: begin
                                op_a      <= a;
                                op_b      <= b;
                                is_signed <= (mdop == MDOP_MULT);
                                is_div    <= 1'b0;
                                acc       <= '0;
                                cnt       <= '0;
                                busy      <= 1'b1;
                                state     <= MUL;
                            end
                            MDOP_DIV, MDOP_DIVU: begin
                                op_a      <= a;
                                op_b      <= b;
                                is_signed <= (mdop == MDOP_DIV);
                                is_div    <= 1'b1;
                                acc       <= '0;
                                cnt       <= '0;
                                busy      <= 1'b1;
                                state     <= DIV;
                            end
                            MDOP_MTHI: hi <= a;
                            MDOP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_last) state <= FIX;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_last) state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO,
// an independent monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mdop  (mdop),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: hi=%h lo=%h, required no done", hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, " hi"}, hi, mon_e.hi);
                check({mon_e.name, " lo"}, lo, mon_e.lo);
            end
        end
    end

    // Issue one multicycle op as a one-cycle start pulse; b2b issues in the
    // current (DONE) cycle instead of waiting for the next negedge.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] op_a,
                         input logic [31:0] op_b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input bit b2b);
        exp_t e;
        int   n;
        int   stall_low;
        if (!b2b) @(negedge clk);
        start = 1'b1;
        mdop  = op;
        a     = op_a;
        b     = op_b;
        #1;
        check({name, " stall_at_issue"}, 32'(stall), b2b ? 32'd0 : 32'd1);
        e.hi   = e_hi;
        e.lo   = e_lo;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        n         = 0;
        stall_low = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (stall !== 1'b1) stall_low++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(n), 32'd33);
        check({name, " stall_low_while_busy"}, 32'(stall_low), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mdop  = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);

        issue("multu_max", MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue("mult_neg3x7", MDOP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        issue("mult_min_x2", MDOP_MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        issue("div_neg7_2", MDOP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue("divu_100_7", MDOP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        issue("divu_by_zero", MDOP_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b0);
        issue("div_neg_by_zero", MDOP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
        issue("div_overflow", MDOP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        issue("div_7_neg2", MDOP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        issue("multu_b2b", MDOP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);

        // MTHI then MTLO with start held, then a reserved op
        @(negedge clk);
        start = 1'b1;
        mdop  = MDOP_MTHI;
        a     = 32'hCAFEBABE;
        #1;
        check("mthi stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("mthi hi", hi, 32'hCAFEBABE);
        check("mthi busy", 32'(busy), 32'd0);
        check("mthi done", 32'(done), 32'd0);
        mdop = MDOP_MTLO;
        a    = 32'h12345678;
        #1;
        check("mtlo stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("mtlo lo", lo, 32'h12345678);
        check("mtlo hi_kept", hi, 32'hCAFEBABE);
        check("mtlo done", 32'(done), 32'd0);
        mdop = 3'd6;
        a    = 32'hDEADBEEF;
        b    = 32'h0BADF00D;
        #1;
        check("rsvd stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rsvd hi", hi, 32'hCAFEBABE);
        check("rsvd lo", lo, 32'h12345678);
        check("rsvd busy", 32'(busy), 32'd0);
        start = 1'b0;

        // Abort a MULT mid-iteration with reset
        @(negedge clk);
        start = 1'b1;
        mdop  = MDOP_MULT;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort stall", 32'(stall), 32'd0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        issue("mult_after_rst", MDOP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, next to the single-cycle ALU.
- Takes the same forwarded a/b operands the ALU consumes.
- Executes MULT/MULTU/DIV/DIVU over 32 cycles and holds results in HI/LO.
- Asserts stall to the hazard/halt logic while busy, so dependent instructions freeze in ID/EX.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX-stage instruction valid for this unit; sampled each cycle
- mdop  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=reserved (ignored)
- a  in  32  rs operand, after forwarding
- b  in  32  rt operand, after forwarding
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse when HI/LO receive a multicycle result
- stall  out  1  to hazard unit: busy, or (start and mdop<=3 while idle)
- hi  out  32  HI register (MFHI reads it combinationally)
- lo  out  32  LO register (MFLO reads it combinationally)

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, stall=0; counter=0. A rst during MUL/DIV aborts the operation; the partial result is discarded.
- FSM states:
  - IDLE: on start with mdop 0-3, latch operands, go to MUL (0,1) or DIV (2,3), counter=0. On start with mdop 4, hi<=a next edge. On mdop 5, lo<=b... correction: lo<=a (MTLO writes rs). Stay in IDLE for 4/5. mdop 6/7 is a no-op.
  - MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator; counter++ each cycle. At counter==31, go to FIX.
  - DIV: restoring divide, one quotient bit per cycle, 64-bit remainder/quotient register. At counter==31, go to FIX.
  - FIX: apply sign correction, write hi/lo on this edge, go to DONE.
  - DONE: done=1 for one cycle, then IDLE. A start in DONE is accepted as if in IDLE, giving back-to-back operation.
- Latency: start sampled at edge E0; busy=1 from E0 through the edge writing hi/lo (E0+33); done=1 in the cycle after. hi/lo are valid at done.
- stall: combinational = busy OR (state==IDLE AND start AND mdop<=3). The issuing instruction holds in EX, and start stays high while stalled; the unit ignores start whenever busy.
- Signed ops: operate on magnitudes.
  - MULT: product negated if the signs differ.
  - DIV: quotient truncates toward zero and is negated if the signs differ; remainder takes the sign of the dividend.
- MULT/MULTU result: hi = product[63:32], lo = product[31:0].
- DIV/DIVU result: lo = quotient, hi = remainder.
- Divide by zero: full latency kept; lo=32'hFFFFFFFF, hi=a. No trap.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
- a/b changing after start do not affect an operation in flight (operands latched).
- MTHI/MTLO while busy: ignored, because stall holds them in EX until IDLE.

Decomposition:
- Shared package/defines file: MDOP_* encodings, FSM state constants (IDLE, MUL, DIV, FIX, DONE), WIDTH.
- One natural sub-module: md_sign_fix, combinational magnitude/negation and result sign correction, shared by the MUL and DIV paths.
- The FSM, counter and datapath stay in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 busy cycles, hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high from the start cycle until done.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xCAFEBABE, then MTLO a=0x12345678 with start held -> hi/lo updated one edge each, stall stays 0, done stays 0.
- rst asserted at iteration 10 of MULT 5x6 -> next cycle busy=0, hi=lo=0, no done; new MULT 5x6 then gives lo=30, hi=0.
